// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared state encoding and mode constants for scan_decoder
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// rtl/scan_decoder_onehot_dec.sv - combinational SEL_W to 2**SEL_W one-hot decoder
module onehot_dec #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      i_sel,
   output logic [(1<<SEL_W)-1:0] o_y
);

   always_comb begin
      o_y        = '0;
      o_y[i_sel] = 1'b1;
   end

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered one-hot decoder with direct and autonomous scan modes
// Define SCAN_DECODER_ACTIVE_LOW_EN for active-low y outputs.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_mode,
   input  logic [SEL_W-1:0]      i_sel,
   input  logic [DWELL_W-1:0]    i_dwell,
   output logic [(1<<SEL_W)-1:0] o_y,
   output logic [SEL_W-1:0]      o_idx,
   output logic                  o_wrap
);

   localparam int N = 1 << SEL_W;

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
   localparam logic [N-1:0] Y_POL = '1;
`else
   localparam logic [N-1:0] Y_POL = '0;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SEL_W-1:0]   r_idx;
   logic [SEL_W-1:0]   w_idx_nxt;
   logic [DWELL_W-1:0] r_cnt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               r_wrap;
   logic               w_wrap_nxt;
   logic [N-1:0]       r_y;
   logic [N-1:0]       w_dec;
   logic [N-1:0]       w_y_nxt;

   onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .i_sel (w_idx_nxt),
      .o_y   (w_dec)
   );

   always_comb begin
      w_state_nxt = IDLE;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = '0;
      w_wrap_nxt  = 1'b0;
      if (i_en) begin
         w_state_nxt = (i_mode == MODE_SCAN) ? SCAN : DIRECT;
      end
      case (w_state_nxt)
         DIRECT: w_idx_nxt = i_sel;
         SCAN: begin
            // Any entry into SCAN restarts the walk; the old position is never resumed.
            if (r_state != SCAN) begin
               w_idx_nxt = '0;
            end else if (r_cnt >= i_dwell) begin
               w_idx_nxt  = r_idx + SEL_W'(1);
               w_wrap_nxt = &r_idx;
            end else begin
               w_cnt_nxt = r_cnt + DWELL_W'(1);
            end
         end
         default: ;
      endcase
      // Decoding the next index keeps y one-hot on the very cycle idx changes.
      w_y_nxt = (w_state_nxt == IDLE) ? '0 : w_dec;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_wrap  <= 1'b0;
         r_y     <= Y_POL;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wrap  <= w_wrap_nxt;
         r_y     <= w_y_nxt ^ Y_POL;
      end
   end

   assign o_y    = r_y;
   assign o_idx  = r_idx;
   assign o_wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder (table vectors plus scoreboard)
module tb_scan_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_en, a_mode, a_wrap;
   logic [2:0] a_sel, a_idx;
   logic [7:0] a_dwell, a_y;

   logic        b_rst, b_en, b_mode, b_wrap;
   logic [3:0]  b_sel, b_idx, b_dwell;
   logic [15:0] b_y;

   scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_en(a_en), .i_mode(a_mode), .i_sel(a_sel),
      .i_dwell(a_dwell), .o_y(a_y), .o_idx(a_idx), .o_wrap(a_wrap)
   );

   scan_decoder #(.SEL_W(4), .DWELL_W(4)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_en(b_en), .i_mode(b_mode), .i_sel(b_sel),
      .i_dwell(b_dwell), .o_y(b_y), .o_idx(b_idx), .o_wrap(b_wrap)
   );

   typedef struct {
      int          dut;
      logic [15:0] y;
      logic [3:0]  idx;
      logic        wrap;
   } exp_t;

   typedef struct {
      logic       rst, en, mode;
      logic [2:0] sel;
      logic [7:0] dwell;
      logic [7:0] y;
      logic [2:0] idx;
      logic       wrap;
   } vec_t;

   exp_t sbq[$];
   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   int   m_scan = 0, m_idx = 0, m_hold = 0;

   function automatic logic [15:0] phys(input logic [15:0] v, input int n);
      logic [15:0] m;
      m = (n == 16) ? 16'hFFFF : 16'h00FF;
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
      return ~v & m;
`else
      return v & m;
`endif
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_pop();
      exp_t e;
      if (sbq.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
         return;
      end
      e = sbq.pop_front();
      if (e.dut == 0) begin
         cmp("a_y", {8'h00, a_y}, phys(e.y, 8));
         cmp("a_idx", {13'h0, a_idx}, {13'h0, e.idx[2:0]});
         cmp("a_wrap", {15'h0, a_wrap}, {15'h0, e.wrap});
      end else begin
         cmp("b_y", b_y, phys(e.y, 16));
         cmp("b_idx", {12'h0, b_idx}, {12'h0, e.idx});
         cmp("b_wrap", {15'h0, b_wrap}, {15'h0, e.wrap});
      end
   endtask

   task automatic step_a(input logic rst, en, mode, input logic [2:0] sel, input logic [7:0] dwell,
                         input logic [15:0] ey, input logic [3:0] eidx, input logic ew);
      exp_t e;
      a_rst = rst; a_en = en; a_mode = mode; a_sel = sel; a_dwell = dwell;
      e.dut = 0; e.y = ey; e.idx = eidx; e.wrap = ew;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic step_b(input logic rst, en, mode, input logic [3:0] dwell,
                         input logic [15:0] ey, input logic [3:0] eidx, input logic ew);
      exp_t e;
      b_rst = rst; b_en = en; b_mode = mode; b_sel = 4'd0; b_dwell = dwell;
      e.dut = 1; e.y = ey; e.idx = eidx; e.wrap = ew;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   // Behavioural reference for the 8-output instance: tracks how long the current index has been held.
   task automatic step_ma(input logic rst, en, mode, input logic [2:0] sel, input logic [7:0] dwell);
      logic [15:0] ey;
      logic        ew;
      ew = 1'b0;
      if (rst) begin
         m_scan = 0; m_idx = 0; m_hold = 0; ey = 16'h0;
      end else if (!en) begin
         m_scan = 0; m_hold = 0; ey = 16'h0;
      end else if (!mode) begin
         m_scan = 0; m_hold = 0; m_idx = int'(sel); ey = 16'd1 << m_idx;
      end else if (m_scan == 0) begin
         m_scan = 1; m_idx = 0; m_hold = 0; ey = 16'd1;
      end else begin
         if (m_hold >= int'(dwell)) begin
            m_idx  = (m_idx + 1) % 8;
            m_hold = 0;
            ew     = (m_idx == 0);
         end else begin
            m_hold++;
         end
         ey = 16'd1 << m_idx;
      end
      step_a(rst, en, mode, sel, dwell, ey, 4'(m_idx), ew);
   endtask

   initial begin
      int first_wrap;
      int n_wrap;
      logic r_mode;

      a_rst = 1'b1; a_en = 1'b1; a_mode = 1'b0; a_sel = 3'd0; a_dwell = 8'd0;
      b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_sel = 4'd0; b_dwell = 4'd0;

      tbl.push_back('{1, 1, 0, 3'd5, 8'd0, 8'h00, 3'd0, 0});
      tbl.push_back('{1, 1, 0, 3'd5, 8'd0, 8'h00, 3'd0, 0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{0, 1, 0, 3'(i), 8'd0, 8'(1 << i), 3'(i), 0});
      tbl.push_back('{0, 1, 1, 3'd0, 8'd0, 8'h01, 3'd0, 0});
      for (int i = 1; i < 8; i++)
         tbl.push_back('{0, 1, 1, 3'd0, 8'd0, 8'(1 << i), 3'(i), 0});
      tbl.push_back('{0, 1, 1, 3'd0, 8'd0, 8'h01, 3'd0, 1});
      tbl.push_back('{0, 1, 1, 3'd0, 8'd0, 8'h02, 3'd1, 0});
      tbl.push_back('{0, 1, 0, 3'd6, 8'd0, 8'h40, 3'd6, 0});
      tbl.push_back('{0, 0, 0, 3'd2, 8'd0, 8'h00, 3'd6, 0});
      tbl.push_back('{0, 1, 1, 3'd2, 8'd0, 8'h01, 3'd0, 0});
      tbl.push_back('{1, 1, 1, 3'd2, 8'd0, 8'h00, 3'd0, 0});

      for (int i = 0; i < tbl.size(); i++)
         step_a(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].dwell,
                {8'h00, tbl[i].y}, {1'b0, tbl[i].idx}, tbl[i].wrap);

      // dwell=2: each output held 3 cycles, wrap 24 cycles after entry
      first_wrap = -1;
      n_wrap = 0;
      for (int k = 0; k < 50; k++) begin
         step_a(0, 1, 1, 3'd0, 8'd2, 16'd1 << ((k / 3) % 8), 4'((k / 3) % 8),
                (k > 0) && (k % 24 == 0));
         if (a_wrap) begin
            n_wrap++;
            if (first_wrap < 0) first_wrap = k;
         end
      end
      cmp("first_wrap_cycle", 16'(first_wrap), 16'd24);
      cmp("wrap_pulse_count", 16'(n_wrap), 16'd2);

      // dwell lowered 5 -> 0 mid-hold ends the hold on the next cycle
      step_ma(1, 1, 1, 3'd0, 8'd5);
      step_ma(0, 1, 1, 3'd0, 8'd5);
      step_ma(0, 1, 1, 3'd0, 8'd5);
      step_ma(0, 1, 1, 3'd0, 8'd5);
      step_ma(0, 1, 1, 3'd0, 8'd0);
      cmp("dwell_drop_idx", {13'h0, a_idx}, 16'd1);

      // disable at idx 5, then re-enable restarts at 0
      for (int k = 0; k < 4; k++) step_ma(0, 1, 1, 3'd0, 8'd0);
      step_ma(0, 0, 1, 3'd0, 8'd0);
      step_ma(0, 1, 1, 3'd0, 8'd0);
      for (int k = 0; k < 3; k++) step_ma(0, 1, 1, 3'd0, 8'd0);
      step_ma(0, 1, 0, 3'd6, 8'd0);

      // reach idx 3 with dwell=1, pulse rst between edges, then reset on an edge
      for (int k = 0; k < 7; k++) step_ma(0, 1, 1, 3'd0, 8'd1);
      a_rst = 1'b1;
      #2;
      a_rst = 1'b0;
      #1;
      cmp("rst_between_edges_idx", {13'h0, a_idx}, 16'd3);
      cmp("rst_between_edges_y", {8'h00, a_y}, phys(16'h0008, 8));
      step_ma(0, 1, 1, 3'd0, 8'd1);
      step_ma(1, 1, 1, 3'd0, 8'd1);

      r_mode = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(9) == 0) r_mode = ~r_mode;
         step_ma($urandom_range(39) == 0, $urandom_range(7) != 0, r_mode,
                 3'($urandom_range(7)), 8'($urandom_range(3)));
      end

      // 16-output instance, dwell=15: each output held 16 cycles
      step_b(1, 1, 1, 4'd15, 16'h0000, 4'd0, 0);
      for (int k = 0; k < 258; k++)
         step_b(0, 1, 1, 4'd15, 16'd1 << ((k / 16) % 16), 4'((k / 16) % 16), k == 256);
      step_b(0, 1, 0, 4'd15, 16'h0001, 4'd0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
